// File: rtl/peak_search_ctrl_pkg.sv
// Shared acquisition definitions for the peak search: amplitude/word geometry,
// lane packing offsets and the controller state encoding.
package peak_search_ctrl_pkg;

  localparam int AMP_W     = 9;
  localparam int LANES     = 4;
  localparam int WORD_W    = AMP_W * LANES;
  localparam int LANE0_OFF = 0;
  localparam int LANE1_OFF = 9;
  localparam int LANE2_OFF = 18;
  localparam int LANE3_OFF = 27;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Lane 0 is amp1 in the low bits; lane 3 is amp4 in the high bits.
  function automatic logic [AMP_W-1:0] lane_amp(input logic [WORD_W-1:0] w,
                                                 input logic [1:0]        idx);
    logic [AMP_W-1:0] a;
    case (idx)
      2'd0:    a = w[LANE0_OFF +: AMP_W];
      2'd1:    a = w[LANE1_OFF +: AMP_W];
      2'd2:    a = w[LANE2_OFF +: AMP_W];
      2'd3:    a = w[LANE3_OFF +: AMP_W];
      default: a = {AMP_W{1'b0}};
    endcase
    return a;
  endfunction

endpackage

// File: rtl/peak_search_ctrl_if.sv
// Control, buffer-read and result bundle of the peak search controller.
// The slave modport is the controller's view; master is the firmware/buffer side.
interface peak_search_ctrl_if #(
  parameter int ADDR_WIDTH = 10
) ();
  import peak_search_ctrl_pkg::*;

  logic                    start;
  logic                    abort;
  logic [ADDR_WIDTH-1:0]   base_addr;
  logic [ADDR_WIDTH:0]     word_count;
  logic                    rd_en;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [WORD_W-1:0]       rd_data;
  logic                    busy;
  logic                    done;
  logic [AMP_W-1:0]        peak_amp;
  logic [ADDR_WIDTH+1:0]   peak_pos;
  logic [AMP_W-1:0]        second_amp;
  logic [ADDR_WIDTH+10:0]  amp_sum;

  modport slave (
    input  start, abort, base_addr, word_count, rd_data,
    output rd_en, rd_addr, busy, done, peak_amp, peak_pos, second_amp, amp_sum
  );

  modport master (
    output start, abort, base_addr, word_count, rd_data,
    input  rd_en, rd_addr, busy, done, peak_amp, peak_pos, second_amp, amp_sum
  );

endinterface

// File: rtl/amp_compare.sv
// Combinational maximum of the four packed amplitudes of one word; equal
// amplitudes resolve to the lower lane.
module amp_compare
  import peak_search_ctrl_pkg::*;
(
  input  logic [WORD_W-1:0] word_i,
  output logic [AMP_W-1:0]  max_o,
  output logic [1:0]        lane_o
);

  logic [AMP_W-1:0] a0_s, a1_s, a2_s, a3_s;
  logic [AMP_W-1:0] lo_max_s, hi_max_s;
  logic [1:0]       lo_lane_s, hi_lane_s;

  assign a0_s = lane_amp(word_i, 2'd0);
  assign a1_s = lane_amp(word_i, 2'd1);
  assign a2_s = lane_amp(word_i, 2'd2);
  assign a3_s = lane_amp(word_i, 2'd3);

  // Strict compares at every level keep the lower lane on ties.
  always_comb begin
    lo_max_s  = a0_s;
    lo_lane_s = 2'd0;
    hi_max_s  = a2_s;
    hi_lane_s = 2'd2;
    max_o     = a0_s;
    lane_o    = 2'd0;
    if (a1_s > a0_s) begin
      lo_max_s  = a1_s;
      lo_lane_s = 2'd1;
    end else begin
      lo_max_s  = a0_s;
      lo_lane_s = 2'd0;
    end
    if (a3_s > a2_s) begin
      hi_max_s  = a3_s;
      hi_lane_s = 2'd3;
    end else begin
      hi_max_s  = a2_s;
      hi_lane_s = 2'd2;
    end
    if (hi_max_s > lo_max_s) begin
      max_o  = hi_max_s;
      lane_o = hi_lane_s;
    end else begin
      max_o  = lo_max_s;
      lane_o = lo_lane_s;
    end
  end

endmodule

// File: rtl/peak_search_ctrl.sv
// Peak search sequencer: streams a block of amplitude words and tracks the global
// peak, its position and the runner-up word peak. Define PEAK_SUM_EN for amp_sum.
module peak_search_ctrl
  import peak_search_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic              clk,
  input  logic              rst,
  peak_search_ctrl_if.slave bus
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam int POS_W = ADDR_WIDTH + 2;
  localparam int SUM_W = ADDR_WIDTH + 11;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] rd_off_q, rd_off_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  rd_en_q, rd_en_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  rd_vld_q, rd_vld_d;
  logic [ADDR_WIDTH-1:0] wd_off_q, wd_off_d;
  logic [AMP_W-1:0]      peak_amp_q, peak_amp_d;
  logic [POS_W-1:0]      peak_pos_q, peak_pos_d;
  logic [AMP_W-1:0]      second_amp_q, second_amp_d;

  logic                  accept_s;
  logic                  last_rd_s;
  logic                  clr_s;
  logic                  upd_s;
  logic [ADDR_WIDTH-1:0] rd_off_inc_s;
  logic [AMP_W-1:0]      word_max_s;
  logic [1:0]            word_lane_s;

  amp_compare u_amp_compare (
    .word_i (bus.rd_data),
    .max_o  (word_max_s),
    .lane_o (word_lane_s)
  );

  assign accept_s     = (state_q == IDLE) && bus.start && !bus.abort;
  assign clr_s        = accept_s;
  assign upd_s        = rd_vld_q && !bus.abort;
  assign rd_off_inc_s = rd_off_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  // rd_off_q is the offset of the read on the bus this cycle; +1 is reads issued.
  assign last_rd_s    = (({1'b0, rd_off_q} + {{ADDR_WIDTH{1'b0}}, 1'b1}) == cnt_q);

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    cnt_d     = cnt_q;
    rd_off_d  = rd_off_q;
    rd_addr_d = rd_addr_q;
    rd_en_d   = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    if (bus.abort) begin
      state_d = IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            base_d    = bus.base_addr;
            cnt_d     = bus.word_count;
            rd_off_d  = {ADDR_WIDTH{1'b0}};
            rd_addr_d = bus.base_addr;
            busy_d    = 1'b1;
            if (bus.word_count == {CNT_W{1'b0}}) begin
              state_d = DRAIN;
            end else begin
              state_d = READ;
              rd_en_d = 1'b1;
            end
          end else begin
            busy_d = 1'b0;
          end
        end
        READ: begin
          if (last_rd_s) begin
            state_d = DRAIN;
          end else begin
            rd_en_d   = 1'b1;
            rd_off_d  = rd_off_inc_s;
            rd_addr_d = base_q + rd_off_inc_s;
          end
        end
        DRAIN: begin
          state_d = DONE;
          done_d  = 1'b1;
        end
        DONE: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // Abort kills the read returning next cycle as well as the one being processed now.
  always_comb begin
    rd_vld_d = rd_en_q && !bus.abort;
    wd_off_d = rd_off_q;
  end

  always_comb begin
    peak_amp_d   = peak_amp_q;
    peak_pos_d   = peak_pos_q;
    second_amp_d = second_amp_q;
    if (clr_s) begin
      peak_amp_d   = {AMP_W{1'b0}};
      peak_pos_d   = {POS_W{1'b0}};
      second_amp_d = {AMP_W{1'b0}};
    end else if (upd_s) begin
      if (word_max_s > peak_amp_q) begin
        second_amp_d = peak_amp_q;
        peak_amp_d   = word_max_s;
        peak_pos_d   = {wd_off_q, word_lane_s};
      end else if (word_max_s > second_amp_q) begin
        second_amp_d = word_max_s;
      end else begin
        second_amp_d = second_amp_q;
      end
    end else begin
      peak_amp_d = peak_amp_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      base_q       <= {ADDR_WIDTH{1'b0}};
      cnt_q        <= {CNT_W{1'b0}};
      rd_off_q     <= {ADDR_WIDTH{1'b0}};
      rd_addr_q    <= {ADDR_WIDTH{1'b0}};
      rd_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rd_vld_q     <= 1'b0;
      wd_off_q     <= {ADDR_WIDTH{1'b0}};
      peak_amp_q   <= {AMP_W{1'b0}};
      peak_pos_q   <= {POS_W{1'b0}};
      second_amp_q <= {AMP_W{1'b0}};
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      cnt_q        <= cnt_d;
      rd_off_q     <= rd_off_d;
      rd_addr_q    <= rd_addr_d;
      rd_en_q      <= rd_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rd_vld_q     <= rd_vld_d;
      wd_off_q     <= wd_off_d;
      peak_amp_q   <= peak_amp_d;
      peak_pos_q   <= peak_pos_d;
      second_amp_q <= second_amp_d;
    end
  end

`ifdef PEAK_SUM_EN
  logic [SUM_W-1:0] amp_sum_q, amp_sum_d;
  logic [AMP_W+1:0] word_sum_s;

  assign word_sum_s = {2'b00, lane_amp(bus.rd_data, 2'd0)}
                    + {2'b00, lane_amp(bus.rd_data, 2'd1)}
                    + {2'b00, lane_amp(bus.rd_data, 2'd2)}
                    + {2'b00, lane_amp(bus.rd_data, 2'd3)};

  always_comb begin
    amp_sum_d = amp_sum_q;
    if (clr_s) begin
      amp_sum_d = {SUM_W{1'b0}};
    end else if (upd_s) begin
      amp_sum_d = amp_sum_q + {{(SUM_W-AMP_W-2){1'b0}}, word_sum_s};
    end else begin
      amp_sum_d = amp_sum_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      amp_sum_q <= {SUM_W{1'b0}};
    end else begin
      amp_sum_q <= amp_sum_d;
    end
  end

  assign bus.amp_sum = amp_sum_q;
`else
  assign bus.amp_sum = {SUM_W{1'b0}};
`endif

  assign bus.rd_en      = rd_en_q;
  assign bus.rd_addr    = rd_addr_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.peak_amp   = peak_amp_q;
  assign bus.peak_pos   = peak_pos_q;
  assign bus.second_amp = second_amp_q;

endmodule

// File: tb/tb_peak_search_ctrl.sv
// Directed bench for peak_search_ctrl: a buffer model feeds reads, a reference
// model fills a scoreboard at each start, and results are checked at done.
module tb_peak_search_ctrl;
  import peak_search_ctrl_pkg::*;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  typedef struct packed {
    logic [AMP_W-1:0] pa;
    logic [AW+1:0]    pp;
    logic [AMP_W-1:0] sa;
    logic [AW+10:0]   sum;
  } res_t;

  logic              clk;
  logic              rst;
  logic [WORD_W-1:0] mem [DEPTH];
  res_t              exp_q[$];
  logic [AW-1:0]     addr_q[$];
  res_t              last_e;
  int                n_cmp;
  int                n_mis;

  peak_search_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  peak_search_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer model: data one cycle after rd_en, all-ones junk otherwise.
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
    else           bus.rd_data <= {WORD_W{1'b1}};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [WORD_W-1:0] pk(input int a1, input int a2, input int a3, input int a4);
    logic [8:0] b1, b2, b3, b4;
    b1 = a1[8:0]; b2 = a2[8:0]; b3 = a3[8:0]; b4 = a4[8:0];
    return {b4, b3, b2, b1};
  endfunction

  // Peak = first strictly larger amplitude; second = best word max of the other words.
  function automatic res_t model(input int base, input int n);
    res_t r;
    int   wmax[$];
    int   pw, wm, wl, a;
    logic [WORD_W-1:0] w;
    logic [AW-1:0] ko;
    logic [1:0]    lo;
    r  = '0;
    pw = -1;
    for (int k = 0; k < n; k++) begin
      w  = mem[(base + k) % DEPTH];
      wm = -1;
      wl = 0;
      for (int l = 0; l < 4; l++) begin
        a = int'(w[9*l +: 9]);
`ifdef PEAK_SUM_EN
        r.sum = r.sum + 21'(a);
`endif
        if (a > wm) begin
          wm = a;
          wl = l;
        end
      end
      wmax.push_back(wm);
      if (wm > int'(r.pa)) begin
        ko   = k[AW-1:0];
        lo   = wl[1:0];
        r.pa = wm[8:0];
        r.pp = {ko, lo};
        pw   = k;
      end
    end
    for (int k = 0; k < n; k++) begin
      a = wmax[k];
      if (k != pw && a > int'(r.sa)) r.sa = a[8:0];
    end
    return r;
  endfunction

  task automatic run_scan(input string tag, input int base, input int n, input int poke_cyc);
    res_t e;
    int   done_cyc;
    int   nrd;
    logic [AW-1:0] ea;
    e = model(base, n);
    exp_q.push_back(e);
    for (int k = 0; k < n; k++) addr_q.push_back(AW'((base + k) % DEPTH));
    bus.base_addr  = AW'(base);
    bus.word_count = 11'(n);
    bus.start      = 1'b1;
    done_cyc = -1;
    nrd      = 0;
    for (int cyc = 1; cyc <= n + 10 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      bus.start = (cyc == poke_cyc);
      if (cyc == poke_cyc) begin
        bus.base_addr  = AW'(500);
        bus.word_count = 11'(7);
      end
      check({tag, "_busy"}, 32'(bus.busy), 32'(cyc <= n + 2));
      if (bus.rd_en) begin
        nrd++;
        if (addr_q.size() > 0) begin
          ea = addr_q.pop_front();
          check({tag, "_rd_addr"}, 32'(bus.rd_addr), 32'(ea));
        end
      end
      if (bus.done) done_cyc = cyc;
    end
    bus.start = 1'b0;
    check({tag, "_done_cycle"}, 32'(done_cyc), 32'(n + 2));
    check({tag, "_rd_count"}, 32'(nrd), 32'(n));
    addr_q.delete();
    e = exp_q.pop_front();
    last_e = e;
    check({tag, "_peak_amp"},   32'(bus.peak_amp),   32'(e.pa));
    check({tag, "_peak_pos"},   32'(bus.peak_pos),   32'(e.pp));
    check({tag, "_second_amp"}, 32'(bus.second_amp), 32'(e.sa));
    check({tag, "_amp_sum"},    32'(bus.amp_sum),    32'(e.sum));
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(bus.done), 32'(0));
    check({tag, "_busy_after"}, 32'(bus.busy), 32'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int nd, nr;
    int exp_sum;
    n_cmp = 0;
    n_mis = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.base_addr = '0;
    bus.word_count = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = {4'($urandom), 32'($urandom)};
    repeat (3) @(negedge clk);
    check("rst_busy",     32'(bus.busy),       32'(0));
    check("rst_done",     32'(bus.done),       32'(0));
    check("rst_rd_en",    32'(bus.rd_en),      32'(0));
    check("rst_rd_addr",  32'(bus.rd_addr),    32'(0));
    check("rst_peak",     32'(bus.peak_amp),   32'(0));
    check("rst_pos",      32'(bus.peak_pos),   32'(0));
    check("rst_second",   32'(bus.second_amp), 32'(0));
    check("rst_sum",      32'(bus.amp_sum),    32'(0));
    rst = 1'b0;
    @(negedge clk);

    // Basic scan, with a stray start in cycle 2 that must be ignored.
    mem[0] = pk(10, 3, 2, 1);
    mem[1] = pk(4, 20, 300, 7);
    mem[2] = pk(0, 0, 0, 299);
    mem[3] = pk(0, 0, 5, 0);
    run_scan("basic", 0, 4, 2);
    check("basic_peak_const",   32'(bus.peak_amp),   32'(300));
    check("basic_pos_const",    32'(bus.peak_pos),   32'(6));
    check("basic_second_const", 32'(bus.second_amp), 32'(299));

    // Equal amplitudes everywhere: first lane of first word wins.
    for (int k = 10; k < 13; k++) mem[k] = pk(77, 77, 77, 77);
    run_scan("tie", 10, 3, 0);
    check("tie_peak_const",   32'(bus.peak_amp),   32'(77));
    check("tie_pos_const",    32'(bus.peak_pos),   32'(0));
    check("tie_second_const", 32'(bus.second_amp), 32'(77));

    // Address wrap: peak at offset 2 (address 0), lane 1.
    mem[1022] = pk(50, 1, 2, 3);
    mem[1023] = pk(9, 60, 9, 9);
    mem[0]    = pk(8, 400, 400, 8);
    mem[1]    = pk(20, 0, 0, 0);
    run_scan("wrap", DEPTH - 2, 4, 0);
    check("wrap_pos_const", 32'(bus.peak_pos), 32'(9));

    // Abort in cycle 3 of an 8-word scan.
    bus.base_addr = AW'(100);
    bus.word_count = 11'(8);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_rd_en_before", 32'(bus.rd_en), 32'(1));
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_rd_en",  32'(bus.rd_en), 32'(0));
    check("abort_busy",   32'(bus.busy),  32'(0));
    check("abort_done",   32'(bus.done),  32'(0));
    nd = 0;
    nr = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done)  nd++;
      if (bus.rd_en) nr++;
    end
    check("abort_no_done", 32'(nd), 32'(0));
    check("abort_no_read", 32'(nr), 32'(0));
    run_scan("post_abort", 200, 5, 0);

    // start with abort in IDLE: dropped, trackers untouched.
    bus.base_addr = AW'(0);
    bus.word_count = 11'(4);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("sa_busy",  32'(bus.busy),     32'(0));
    check("sa_rd_en", 32'(bus.rd_en),    32'(0));
    check("sa_peak",  32'(bus.peak_amp), 32'(last_e.pa));
    @(negedge clk);
    check("sa_busy2", 32'(bus.busy),     32'(0));

    // Empty block.
    run_scan("empty", 40, 0, 0);

    // Saturated lanes for the accumulator.
    mem[300] = {WORD_W{1'b1}};
    mem[301] = {WORD_W{1'b1}};
    run_scan("sum", 300, 2, 0);
`ifdef PEAK_SUM_EN
    exp_sum = 4088;
`else
    exp_sum = 0;
`endif
    check("sum_const", 32'(bus.amp_sum), 32'(exp_sum));
    repeat (3) @(negedge clk);
    check("hold_peak",   32'(bus.peak_amp),   32'(last_e.pa));
    check("hold_second", 32'(bus.second_amp), 32'(last_e.sa));

    // Random block.
    run_scan("rand", 700, 20, 0);

    // Reset in the middle of a scan.
    bus.base_addr = AW'(0);
    bus.word_count = 11'(8);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mrst_rd_en",   32'(bus.rd_en),      32'(0));
    check("mrst_busy",    32'(bus.busy),       32'(0));
    check("mrst_rd_addr", 32'(bus.rd_addr),    32'(0));
    check("mrst_peak",    32'(bus.peak_amp),   32'(0));
    check("mrst_pos",     32'(bus.peak_pos),   32'(0));
    check("mrst_second",  32'(bus.second_amp), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    check("mrst_no_done", 32'(nd), 32'(0));
    run_scan("post_rst", 900, 6, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
